hack_screen_scanout: RTL and testbench
======================================

# hack_screen_scanout

Memory-mapped Hack screen: owns the 8K x 16 screen framebuffer written by the CPU data bus (Hack addresses 0x4000–0x5FFF, pre-decoded upstream), and independently reads it back as a serial 1-bit pixel stream with a valid/ready handshake for a display back end. It is the reader side of the screen region the CPU writes. It sits beside `ram` in the computer top, with the top muxing `data_o` onto the CPU read bus when the address is in the screen region.

## Interface
- `ROW_WORDS`, 32: words per scan row (512 pixels).
- `ROWS`, 256: rows per frame; `ROW_WORDS*ROWS` must be a power of two (default 8192).

- `clk_i`  in  1  single clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `load_i`  in  1  CPU write strobe for the screen region.
- `addr_i`  in  13  CPU word offset within the screen.
- `data_i`  in  16  CPU write data.
- `data_o`  out  16  combinational `mem[addr_i]` for CPU reads.
- `enable_i`  in  1  scan-out request.
- `pix_o`  out  1  pixel, 1 = black.
- `pix_valid_o`  out  1  `pix_o` is valid.
- `pix_ready_i`  in  1  sink accepts the pixel.
- `sol_o`  out  1  with valid: first pixel of a row.
- `sof_o`  out  1  with valid: first pixel of a frame.
- `frames_o`  out  16  completed-frame count; wraps at 16'hFFFF→0.

## Operation
- CPU port: write `mem[addr_i] <= data_i` on the clock edge when `load_i`=1. `data_o` is combinational. Reset does not clear memory.
- Pixel order: row-major. Word `r*ROW_WORDS + c/16`, bit `c%16`. LSB is the leftmost pixel, shifted out first.
- States:
  - IDLE: `pix_valid_o`=0. `word_q`=0, bit index=0.
  - STREAM: `pix_valid_o`=1.
- IDLE→STREAM when `enable_i`=1. This loads the shifter from `rd_q`.
- Read port: every cycle `rd_q <= mem[next_addr]`. `next_addr` is `word_q+1` modulo the frame size, and is 0 in IDLE.
- Transfer = `pix_valid_o & pix_ready_i`. On a transfer the shifter shifts right and the bit index increments.
- Transfer of bit 15:
  - Last word of the frame: `frames_o` increments. If `enable_i`=1, stay in STREAM with `word_q`→0 and the shifter loaded from `rd_q` (word 0). Otherwise go to IDLE.
  - Any other word: `word_q` increments and the shifter loads from `rd_q`.
- `enable_i` deasserted mid-frame: the frame completes, then the block goes idle. It is sampled only in IDLE and at the end-of-frame transfer.
- Read-during-write: a CPU write to the word being prefetched is visible if it occurs at least 1 cycle before the bit-15 transfer. Otherwise the old data is streamed. Words already in the shifter are never updated.
- `sof_o` = valid & `word_q`==0 & bit 0. `sol_o` = valid & `word_q%ROW_WORDS`==0 & bit 0.

## Timing
- Reset values: `pix_valid_o`=0, `pix_o`=0, `sol_o`=0, `sof_o`=0, `frames_o`=0, state IDLE. `data_o` follows memory.
- Reset mid-frame: IDLE on the next edge. The next frame restarts at word 0 with `sof_o`.
- Latency: `enable_i` sampled high in IDLE at edge k gives first pixel valid in cycle k+1, with `sof_o`=1.
- With `pix_ready_i` held high there are no bubbles:
  - 1 pixel per cycle.
  - A frame takes 131072 cycles.
  - Consecutive frames are back-to-back.
- Backpressure: while `pix_valid_o` & !`pix_ready_i`, the outputs `pix_o`, `sol_o` and `sof_o` hold stable.

## Structure
- Package `hack_pkg`:
  - `SCREEN_BASE`=16'h4000, `KBD_ADDR`=16'h6000, `SCREEN_WORDS`=8192.
  - State enum `scan_state_t` {IDLE, STREAM}.
- Sub-module `screen_fb`: 1 write port, 1 async read port (CPU), 1 registered read port (scan). Scan-out FSM, shifter and counters stay in the top.

## Test plan
- Reset, then write word 0=16'h0005 and word 1=16'h8000. Enable with ready held high → pixels 1,0,1,0×13, then 0×15,1; `sof_o` on the first pixel only; `sol_o` at pixels 0, 512, ...
- CPU readback: write 16'hBEEF at offset 8191 → `data_o`=16'hBEEF combinationally when `addr_i`=8191.
- Random ready throttling over one full frame → captured image equals memory. Outputs stay stable on stalls. `frames_o`=1 at the end.
- `enable_i` dropped at word 100 → frame finishes (131072 transfers), then `pix_valid_o`=0 and `frames_o`=1. Holding `enable_i` instead → second frame starts with no gap.
- Write to word n+1 at the cycle of n's bit-14 transfer → new data streamed. Write at the bit-15 transfer cycle → old data streamed.
- `reset_i` at word 4000 → valid=0 on the next cycle and `frames_o`=0. Re-enable → `sof_o` with word 0.

Source files
------------

// File: rtl/hack_screen_scanout_pkg.sv
// Shared constants and scan-out state type for the Hack screen block.
package hack_pkg;
  localparam logic [15:0] SCREEN_BASE  = 16'h4000;
  localparam logic [15:0] KBD_ADDR     = 16'h6000;
  localparam int          SCREEN_WORDS = 8192;

  typedef enum logic {IDLE, STREAM} scan_state_t;
endpackage

// File: rtl/hack_screen_scanout_if.sv
// CPU bus and pixel-stream signals of the Hack screen; master drives, slave is the screen.
interface hack_screen_scanout_if #(parameter int ADDR_W = 13);
  logic              load_i;
  logic [ADDR_W-1:0] addr_i;
  logic [15:0]       data_i;
  logic [15:0]       data_o;
  logic              enable_i;
  logic              pix_o;
  logic              pix_valid_o;
  logic              pix_ready_i;
  logic              sol_o;
  logic              sof_o;
  logic [15:0]       frames_o;

  modport master (
    output load_i, addr_i, data_i, enable_i, pix_ready_i,
    input  data_o, pix_o, pix_valid_o, sol_o, sof_o, frames_o
  );

  modport slave (
    input  load_i, addr_i, data_i, enable_i, pix_ready_i,
    output data_o, pix_o, pix_valid_o, sol_o, sof_o, frames_o
  );
endinterface

// File: rtl/hack_screen_scanout_fb.sv
// Screen framebuffer: one CPU write port, async CPU read port, registered scan read port.
module screen_fb #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [15:0]       wdata_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [15:0]       cpu_rdata_o,
  input  logic [ADDR_W-1:0] scan_addr_i,
  output logic [15:0]       scan_rdata_o
);
  logic [15:0] mem [DEPTH];
  logic [15:0] rd_d, rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Write-first on the scan port, so a write landing one cycle before the shifter reload is still picked up.
  always_comb begin
    rd_d = mem[scan_addr_i];
    if (we_i && (waddr_i == scan_addr_i)) rd_d = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    rd_q <= rd_d;
  end

  assign cpu_rdata_o  = mem[cpu_addr_i];
  assign scan_rdata_o = rd_q;
endmodule

// File: rtl/hack_screen_scanout.sv
// Hack screen: CPU-writable framebuffer plus a serial row-major pixel stream with valid/ready.
module hack_screen_scanout import hack_pkg::*; #(
  parameter int ROW_WORDS = 32,
  parameter int ROWS      = 256
) (
  input logic                   clk_i,
  input logic                   reset_i,
  hack_screen_scanout_if.slave  bus
);
  localparam int                WORDS     = ROW_WORDS * ROWS;
  localparam int                ADDR_W    = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  scan_state_t       state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       shift_q, shift_d;
  logic [15:0]       frames_q, frames_d;
  logic [ADDR_W-1:0] next_addr;
  logic [15:0]       rd_data;
  logic [15:0]       cpu_rdata;
  logic              valid;
  logic              xfer;

  screen_fb #(.DEPTH(WORDS), .ADDR_W(ADDR_W)) u_fb (
    .clk_i        (clk_i),
    .we_i         (bus.load_i),
    .waddr_i      (bus.addr_i),
    .wdata_i      (bus.data_i),
    .cpu_addr_i   (bus.addr_i),
    .cpu_rdata_o  (cpu_rdata),
    .scan_addr_i  (next_addr),
    .scan_rdata_o (rd_data)
  );

  assign valid = (state_q == STREAM);
  assign xfer  = valid && bus.pix_ready_i;

  // Prefetch word 0 while idle or in reset so a restart always begins at the top of the frame.
  assign next_addr = (reset_i || (state_q == IDLE)) ? '0 : word_q + ADDR_W'(1);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    frames_d = frames_q;
    case (state_q)
      IDLE: begin
        word_d = '0;
        bit_d  = '0;
        if (bus.enable_i) begin
          state_d = STREAM;
          shift_d = rd_data;
        end
      end
      STREAM: begin
        if (xfer) begin
          bit_d   = bit_q + 4'd1;
          shift_d = shift_q >> 1;
          if (bit_q == 4'd15) begin
            shift_d = rd_data;
            if (word_q == LAST_WORD) begin
              frames_d = frames_q + 16'd1;
              word_d   = '0;
              if (!bus.enable_i) state_d = IDLE;
            end else begin
              word_d = word_q + ADDR_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      word_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      frames_q <= frames_d;
    end
  end

  assign bus.data_o      = cpu_rdata;
  assign bus.pix_valid_o = valid;
  assign bus.pix_o       = valid && shift_q[0];
  assign bus.sof_o       = valid && (word_q == '0) && (bit_q == 4'd0);
  assign bus.sol_o       = valid && ((int'(word_q) % ROW_WORDS) == 0) && (bit_q == 4'd0);
  assign bus.frames_o    = frames_q;
endmodule

// File: tb/tb_hack_screen_scanout.sv
// Bench for hack_screen_scanout: a full-size instance for the pixel-order/readback cases and a
// 32-word instance (4x8) so whole frames stay short; a queue scoreboard checks every transfer.
module tb_hack_screen_scanout;
  localparam int B_ROW_WORDS = 4;
  localparam int B_ROWS      = 8;
  localparam int B_WORDS     = B_ROW_WORDS * B_ROWS;
  localparam int B_AW        = 5;
  localparam int B_PIX       = B_WORDS * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB;
  hack_screen_scanout_if #(.ADDR_W(13))   ifA();
  hack_screen_scanout_if #(.ADDR_W(B_AW)) ifB();

  hack_screen_scanout dutA (.clk_i(clk), .reset_i(rstA), .bus(ifA));
  hack_screen_scanout #(.ROW_WORDS(B_ROW_WORDS), .ROWS(B_ROWS)) dutB (.clk_i(clk), .reset_i(rstB), .bus(ifB));

  int          errCount   = 0;
  int          checkCount = 0;
  int          xferB      = 0;
  bit          throttle   = 1'b0;
  bit          stallPrev  = 1'b0;
  logic [2:0]  held;
  logic [15:0] memB [B_WORDS];
  logic [2:0]  expQ [$];
  logic [31:0] patA = 32'h8000_0005;
  logic [15:0] newN, newM;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (throttle) ifB.pix_ready_i = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic writeA(input logic [12:0] addr, input logic [15:0] data);
    ifA.load_i = 1'b1;
    ifA.addr_i = addr;
    ifA.data_i = data;
    applyStimulus(1);
    ifA.load_i = 1'b0;
  endtask

  task automatic writeB(input logic [B_AW-1:0] addr, input logic [15:0] data);
    ifB.load_i = 1'b1;
    ifB.addr_i = addr;
    ifB.data_i = data;
    applyStimulus(1);
    ifB.load_i = 1'b0;
    memB[addr] = data;
  endtask

  task automatic resetB();
    rstB = 1'b1;
    ifB.enable_i = 1'b0;
    applyStimulus(2);
    rstB = 1'b0;
    expQ.delete();
    xferB = 0;
  endtask

  // Expected {sof, sol, pix} for every pixel of one frame, taken from the memory model.
  task automatic pushFrame();
    logic [15:0] w;
    for (int p = 0; p < B_PIX; p++) begin
      w = memB[p / 16];
      expQ.push_back({p == 0, (p % 16 == 0) && ((p / 16) % B_ROW_WORDS == 0), w[p % 16]});
    end
  endtask

  task automatic waitXfer(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (xferB < target && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, 32'(xferB), 32'(target));
  endtask

  // Scoreboard pop on each accepted pixel, plus hold check across stalls.
  always @(negedge clk) begin : monB
    logic [2:0] cur;
    cur = {ifB.sof_o, ifB.sol_o, ifB.pix_o};
    if (rstB) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) checkOutput("stall_hold", 32'(cur), 32'(held));
      if (ifB.pix_valid_o && ifB.pix_ready_i) begin
        if (expQ.size() == 0) checkOutput("sb_nonempty", 32'(expQ.size()), 32'd1);
        else checkOutput("pixB", 32'(cur), 32'(expQ.pop_front()));
        xferB++;
      end
      stallPrev = ifB.pix_valid_o && !ifB.pix_ready_i;
      held = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    ifA.load_i = 1'b0; ifA.addr_i = '0; ifA.data_i = '0; ifA.enable_i = 1'b0; ifA.pix_ready_i = 1'b1;
    ifB.load_i = 1'b0; ifB.addr_i = '0; ifB.data_i = '0; ifB.enable_i = 1'b0; ifB.pix_ready_i = 1'b1;
    applyStimulus(3);

    checkOutput("A_rst_valid", 32'(ifA.pix_valid_o), 32'd0);
    checkOutput("A_rst_pix", 32'(ifA.pix_o), 32'd0);
    checkOutput("A_rst_sol", 32'(ifA.sol_o), 32'd0);
    checkOutput("A_rst_sof", 32'(ifA.sof_o), 32'd0);
    checkOutput("A_rst_frames", 32'(ifA.frames_o), 32'd0);
    checkOutput("B_rst_valid", 32'(ifB.pix_valid_o), 32'd0);
    rstA = 1'b0;

    writeA(13'd0, 16'h0005);
    writeA(13'd1, 16'h8000);
    writeA(13'd8191, 16'hBEEF);
    ifA.addr_i = 13'd8191;
    #1 checkOutput("A_readback_8191", 32'(ifA.data_o), 32'hBEEF);
    ifA.addr_i = 13'd0;
    #1 checkOutput("A_readback_0", 32'(ifA.data_o), 32'h0005);

    // Pixel order, sof/sol placement and one-cycle start latency on the full-size screen.
    ifA.enable_i = 1'b1;
    applyStimulus(1);
    checkOutput("A_latency_valid", 32'(ifA.pix_valid_o), 32'd1);
    for (int i = 0; i < 600; i++) begin
      if (i < 32) checkOutput("A_pix", 32'(ifA.pix_o), 32'(patA[i]));
      checkOutput("A_sof", 32'(ifA.sof_o), 32'(i == 0));
      checkOutput("A_sol", 32'(ifA.sol_o), 32'(i % 512 == 0));
      applyStimulus(1);
    end
    ifA.enable_i = 1'b0;
    rstA = 1'b1;
    applyStimulus(1);
    checkOutput("A_rst_mid_valid", 32'(ifA.pix_valid_o), 32'd0);
    rstA = 1'b0;

    rstB = 1'b0;
    for (int w = 0; w < B_WORDS; w++) writeB(B_AW'(w), 16'($urandom));
    for (int w = 0; w < B_WORDS; w += 7) begin
      ifB.addr_i = B_AW'(w);
      #1 checkOutput("B_readback", 32'(ifB.data_o), 32'(memB[w]));
    end

    // Random ready throttling over one whole frame.
    resetB();
    throttle = 1'b1;
    pushFrame();
    ifB.enable_i = 1'b1;
    applyStimulus(1);
    ifB.enable_i = 1'b0;
    checkOutput("B_thr_valid", 32'(ifB.pix_valid_o), 32'd1);
    checkOutput("B_thr_sof", 32'(ifB.sof_o), 32'd1);
    waitXfer("B_thr_xfers", B_PIX, 5000);
    applyStimulus(2);
    checkOutput("B_thr_idle", 32'(ifB.pix_valid_o), 32'd0);
    checkOutput("B_thr_frames", 32'(ifB.frames_o), 32'd1);
    checkOutput("B_thr_queue", 32'(expQ.size()), 32'd0);
    throttle = 1'b0;
    ifB.pix_ready_i = 1'b1;

    // Enable dropped at word 20: the frame still completes, then idle.
    resetB();
    pushFrame();
    ifB.enable_i = 1'b1;
    applyStimulus(1 + 16 * 20);
    ifB.enable_i = 1'b0;
    waitXfer("B_drop_xfers", B_PIX, 1000);
    checkOutput("B_drop_idle", 32'(ifB.pix_valid_o), 32'd0);
    checkOutput("B_drop_frames", 32'(ifB.frames_o), 32'd1);
    checkOutput("B_drop_queue", 32'(expQ.size()), 32'd0);

    // Enable held: two frames back-to-back in exactly 2*B_PIX cycles.
    resetB();
    pushFrame();
    pushFrame();
    ifB.enable_i = 1'b1;
    applyStimulus(600);
    ifB.enable_i = 1'b0;
    applyStimulus(425);
    checkOutput("B_b2b_xfers", 32'(xferB), 32'(2 * B_PIX));
    checkOutput("B_b2b_idle", 32'(ifB.pix_valid_o), 32'd0);
    checkOutput("B_b2b_frames", 32'(ifB.frames_o), 32'd2);
    checkOutput("B_b2b_queue", 32'(expQ.size()), 32'd0);

    // Read-during-write: word 6 written at word 5's bit-14 transfer (new data),
    // word 11 written at word 10's bit-15 transfer (old data).
    resetB();
    newN = ~memB[6];
    newM = ~memB[11];
    memB[6] = newN;
    pushFrame();
    ifB.enable_i = 1'b1;
    applyStimulus(1);
    ifB.enable_i = 1'b0;
    applyStimulus(14 + 16 * 5);
    ifB.load_i = 1'b1; ifB.addr_i = B_AW'(6); ifB.data_i = newN;
    applyStimulus(1);
    ifB.load_i = 1'b0;
    applyStimulus(80);
    ifB.load_i = 1'b1; ifB.addr_i = B_AW'(11); ifB.data_i = newM;
    applyStimulus(1);
    ifB.load_i = 1'b0;
    memB[11] = newM;
    waitXfer("B_rdw_xfers", B_PIX, 1000);
    checkOutput("B_rdw_frames", 32'(ifB.frames_o), 32'd1);
    checkOutput("B_rdw_queue", 32'(expQ.size()), 32'd0);
    ifB.addr_i = B_AW'(11);
    #1 checkOutput("B_rdw_mem", 32'(ifB.data_o), 32'(newM));

    // Reset at word 20 of the second frame, then restart from word 0.
    resetB();
    pushFrame();
    pushFrame();
    ifB.enable_i = 1'b1;
    applyStimulus(1 + B_PIX + 16 * 20);
    checkOutput("B_rstmid_frames_pre", 32'(ifB.frames_o), 32'd1);
    rstB = 1'b1;
    applyStimulus(1);
    checkOutput("B_rstmid_valid", 32'(ifB.pix_valid_o), 32'd0);
    checkOutput("B_rstmid_pix", 32'(ifB.pix_o), 32'd0);
    checkOutput("B_rstmid_sof", 32'(ifB.sof_o), 32'd0);
    checkOutput("B_rstmid_frames", 32'(ifB.frames_o), 32'd0);
    rstB = 1'b0;
    expQ.delete();
    xferB = 0;
    pushFrame();
    applyStimulus(1);
    ifB.enable_i = 1'b0;
    checkOutput("B_restart_valid", 32'(ifB.pix_valid_o), 32'd1);
    checkOutput("B_restart_sof", 32'(ifB.sof_o), 32'd1);
    waitXfer("B_restart_xfers", B_PIX, 1000);
    checkOutput("B_restart_frames", 32'(ifB.frames_o), 32'd1);
    checkOutput("B_restart_queue", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
